display_frame_sequencer: RTL and testbench

DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

---
 rtl/display_frame_sequencer_pkg.sv | 21 ++
 rtl/display_frame_sequencer_serial_bit_timer.sv | 29 ++
 rtl/display_frame_sequencer.sv | 93 +++++++++
 tb/tb_display_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_frame_sequencer_pkg.sv
// Shared display constants: frame/brightness widths, FSM encoding and digit field layout.
package display_frame_sequencer_pkg;
    localparam int FRAME_W   = 96;
    localparam int BRIGHT_W  = 8;
    localparam int DIGIT_W   = 24;
    localparam int RED_OFS   = 16;
    localparam int GRN_OFS   = 8;
    localparam int ANODE_OFS = 0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SHIFT  = 4'b0010,
        ST_STROBE = 4'b0100,
        ST_GAP    = 4'b1000
    } state_t;

    // Digit 1 sits at the bottom of the frame, digit 4 at [95:72].
    function automatic int digit_base(input int digit);
        return (digit - 1) * DIGIT_W;
    endfunction
endpackage

// File: rtl/display_frame_sequencer_serial_bit_timer.sv
// Half-period timer: counts CLK_DIV cycles per phase and flips the serial clock phase.
module serial_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick,
    output logic phase_hi
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] phase_cnt;

    assign tick = run && (phase_cnt == LAST);

    // Holding the counter cleared while idle makes every job start on a fresh low phase.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            phase_cnt <= '0;
            phase_hi  <= 1'b0;
        end else if (tick) begin
            phase_cnt <= '0;
            phase_hi  <= !phase_hi;
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/display_frame_sequencer.sv
// Serialises 96-bit display frames and 8-bit brightness words MSB first, then strobes latch or pwm.
module display_frame_sequencer
    import display_frame_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               bright_valid,
    output logic               bright_ready,
    input  logic [BRIGHT_W-1:0] bright_data,
    output logic               ser_clk,
    output logic               ser_data,
    output logic               ser_latch,
    output logic               ser_pwm,
    output logic               busy
);
    state_t             state, state_next;
    logic [FRAME_W-1:0] shreg;
    logic [6:0]         bit_cnt;
    logic               job_frame;
    logic               pick_frame;
    logic               grant_frame;
    logic               take;
    logic               tick;
    logic               phase_hi;
    logic               bit_done;

    serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != ST_IDLE),
        .tick     (tick),
        .phase_hi (phase_hi)
    );

    // On a tie, the side not served last wins; pick_frame remembers that.
    assign grant_frame = frame_valid && (pick_frame || !bright_valid);
    assign take        = frame_ready || bright_ready;
    assign bit_done    = (state == ST_SHIFT) && tick && phase_hi;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (take) state_next = ST_SHIFT;
            ST_SHIFT:  if (bit_done && bit_cnt == 7'd1) state_next = ST_STROBE;
            ST_STROBE: if (tick) state_next = ST_GAP;
            ST_GAP:    if (tick) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != ST_IDLE);
        frame_ready  = rst_n && (state == ST_IDLE) && grant_frame;
        bright_ready = rst_n && (state == ST_IDLE) && bright_valid && !grant_frame;
        ser_clk      = (state == ST_SHIFT) && phase_hi;
        ser_data     = (state == ST_SHIFT) && shreg[FRAME_W-1];
        ser_latch    = (state == ST_STROBE) && job_frame;
        ser_pwm      = (state == ST_STROBE) && !job_frame;
    end

    // Brightness is left-aligned so both job types shift out of the same MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            job_frame  <= 1'b0;
            pick_frame <= 1'b1;
        end else if (take) begin
            job_frame  <= frame_ready;
            pick_frame <= !frame_ready;
            if (frame_ready) begin
                shreg   <= frame_data;
                bit_cnt <= 7'(FRAME_W);
            end else begin
                shreg   <= {bright_data, {(FRAME_W-BRIGHT_W){1'b0}}};
                bit_cnt <= 7'(BRIGHT_W);
            end
        end else if (bit_done) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 7'd1;
        end
    end
endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed bench: two sequencers (CLK_DIV=1 and CLK_DIV=4) driven from a vector table and corner sequences.
module tb_display_frame_sequencer;
    logic        clk;
    logic        rst_n;
    logic        fv [2];
    logic        bv [2];
    logic [95:0] fd [2];
    logic [7:0]  bd [2];
    logic        fr [2];
    logic        br [2];
    logic        sclk [2];
    logic        sdat [2];
    logic        slat [2];
    logic        spwm [2];
    logic        bsy [2];

    int checks = 0;
    int failures = 0;
    int viol = 0;

    display_frame_sequencer #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(fv[0]), .frame_ready(fr[0]), .frame_data(fd[0]),
        .bright_valid(bv[0]), .bright_ready(br[0]), .bright_data(bd[0]),
        .ser_clk(sclk[0]), .ser_data(sdat[0]), .ser_latch(slat[0]), .ser_pwm(spwm[0]),
        .busy(bsy[0])
    );

    display_frame_sequencer #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(fv[1]), .frame_ready(fr[1]), .frame_data(fd[1]),
        .bright_valid(bv[1]), .bright_ready(br[1]), .bright_data(bd[1]),
        .ser_clk(sclk[1]), .ser_data(sdat[1]), .ser_latch(slat[1]), .ser_pwm(spwm[1]),
        .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol invariants on both instances, every cycle.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if ((slat[s] && spwm[s]) || ((slat[s] || spwm[s]) && sclk[s]) ||
                ((fr[s] || br[s]) && bsy[s]) || (fr[s] && br[s]))
                viol++;
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int s, input string name);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!bsy[s]) break;
            n++;
        end
        check({name, "_idle_timeout"}, 96'(n >= 3000), 96'(0));
    endtask

    task automatic run_job(input int s, input bit is_frame, input logic [95:0] d,
                           output int bits, output logic [95:0] model,
                           output int lat_cyc, output int lat_pul,
                           output int pwm_cyc, output int pwm_pul, output int busy_cyc);
        int n;
        logic pc, pl, pp;
        bits = 0; model = '0; lat_cyc = 0; lat_pul = 0; pwm_cyc = 0; pwm_pul = 0; busy_cyc = 0;
        @(negedge clk);
        if (is_frame) begin fv[s] = 1'b1; fd[s] = d; end
        else begin bv[s] = 1'b1; bd[s] = d[7:0]; end
        #1;
        n = 0;
        while (!(is_frame ? fr[s] : br[s]) && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        check("job_accept_timeout", 96'(n >= 3000), 96'(0));
        @(posedge clk); #1;
        fv[s] = 1'b0; bv[s] = 1'b0;
        pc = 1'b0; pl = 1'b0; pp = 1'b0; n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!bsy[s]) break;
            n++; busy_cyc++;
            if (sclk[s] && !pc) begin bits++; model = {model[94:0], sdat[s]}; end
            if (slat[s]) lat_cyc++;
            if (slat[s] && !pl) lat_pul++;
            if (spwm[s]) pwm_cyc++;
            if (spwm[s] && !pp) pwm_pul++;
            pc = sclk[s]; pl = slat[s]; pp = spwm[s];
        end
    endtask

    typedef struct {
        int          s;
        bit          is_frame;
        logic [95:0] d;
        int          bits;
        int          busy;
        int          strobe;
    } vec_t;

    vec_t vt [5];

    initial begin
        int bits, lat_cyc, lat_pul, pwm_cyc, pwm_pul, busy_cyc, n, early, rises, cnt;
        int off_f, off_b, acc_f, acc_b;
        bit af, ab;
        logic pc;
        logic [95:0] model, expm;

        vt[0] = '{1, 1'b1, {12{8'hA5}},                          96, 776, 4};
        vt[1] = '{0, 1'b0, 96'h80,                                 8,  18, 1};
        vt[2] = '{0, 1'b1, 96'h0123_4567_89AB_CDEF_F00D_CAFE,     96, 194, 1};
        vt[3] = '{1, 1'b0, 96'h01,                                 8,  72, 4};
        vt[4] = '{0, 1'b0, 96'h5A,                                 8,  18, 1};

        for (int s = 0; s < 2; s++) begin
            fv[s] = 1'b0; bv[s] = 1'b0; fd[s] = '0; bd[s] = '0;
        end

        // Reset with a request already pending: nothing may be acknowledged.
        rst_n = 1'b0;
        fv[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs_div1", 96'({fr[0], br[0], sclk[0], sdat[0], slat[0], spwm[0], bsy[0]}), 96'(0));
        check("reset_outputs_div4", 96'({fr[1], br[1], sclk[1], sdat[1], slat[1], spwm[1], bsy[1]}), 96'(0));
        fv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests from reset: frame first, then the waiting brightness.
        @(negedge clk);
        fv[0] = 1'b1; bv[0] = 1'b1; fd[0] = {12{8'h3C}}; bd[0] = 8'h33;
        #1;
        check("arb_first_pair", 96'({fr[0], br[0]}), 96'(2'b10));
        @(posedge clk); #1;
        fv[0] = 1'b0;
        wait_idle(0, "arb1");
        #1;
        check("arb_bright_next", 96'(br[0]), 96'(1));
        @(posedge clk); #1;
        bv[0] = 1'b0;
        wait_idle(0, "arb2");
        fv[0] = 1'b1; bv[0] = 1'b1;
        #1;
        check("arb_second_pair", 96'({fr[0], br[0]}), 96'(2'b10));
        @(posedge clk); #1;
        fv[0] = 1'b0;
        wait_idle(0, "arb3");
        #1;
        check("arb_second_bright", 96'(br[0]), 96'(1));
        @(posedge clk); #1;
        bv[0] = 1'b0;
        wait_idle(0, "arb4");

        // Frame held through a brightness job is taken on the first idle cycle.
        @(negedge clk);
        bv[0] = 1'b1; bd[0] = 8'hC3;
        #1;
        check("held_bright_ready", 96'(br[0]), 96'(1));
        @(posedge clk); #1;
        bv[0] = 1'b0; fv[0] = 1'b1; fd[0] = {12{8'h96}};
        early = 0; n = 0;
        while (n < 3000) begin
            @(negedge clk); #1;
            if (!bsy[0]) break;
            n++;
            if (fr[0]) early++;
        end
        check("held_frame_no_early_ready", 96'(early), 96'(0));
        check("held_frame_busy_len", 96'(n), 96'(18));
        check("held_frame_first_idle", 96'(fr[0]), 96'(1));
        @(posedge clk); #1;
        fv[0] = 1'b0;
        wait_idle(0, "held");

        // Reset in the middle of bit 40 of a frame on the CLK_DIV=4 instance.
        @(negedge clk);
        fv[1] = 1'b1; fd[1] = {12{8'hA5}};
        #1;
        check("abort_accept", 96'(fr[1]), 96'(1));
        @(posedge clk); #1;
        fv[1] = 1'b0;
        rises = 0; pc = 1'b0; n = 0;
        while (rises < 40 && n < 1000) begin
            @(negedge clk); n++;
            if (sclk[1] && !pc) rises++;
            pc = sclk[1];
        end
        check("abort_reached_bit40", 96'(rises), 96'(40));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", 96'({fr[1], br[1], sclk[1], sdat[1], slat[1], spwm[1], bsy[1]}), 96'(0));
        rst_n = 1'b1;
        cnt = 0;
        repeat (900) begin
            @(negedge clk);
            if (slat[1] || bsy[1]) cnt++;
        end
        check("abort_no_resume", 96'(cnt), 96'(0));

        // Vector table: full jobs, downstream shift model and strobe timing.
        for (int i = 0; i < 5; i++) begin
            run_job(vt[i].s, vt[i].is_frame, vt[i].d, bits, model, lat_cyc, lat_pul, pwm_cyc, pwm_pul, busy_cyc);
            expm = vt[i].is_frame ? vt[i].d : {88'd0, vt[i].d[7:0]};
            check($sformatf("vec%0d_bits", i), 96'(bits), 96'(vt[i].bits));
            check($sformatf("vec%0d_model", i), model, expm);
            check($sformatf("vec%0d_busy", i), 96'(busy_cyc), 96'(vt[i].busy));
            check($sformatf("vec%0d_latch_cyc", i), 96'(lat_cyc), 96'(vt[i].is_frame ? vt[i].strobe : 0));
            check($sformatf("vec%0d_latch_pulses", i), 96'(lat_pul), 96'(vt[i].is_frame ? 1 : 0));
            check($sformatf("vec%0d_pwm_cyc", i), 96'(pwm_cyc), 96'(vt[i].is_frame ? 0 : vt[i].strobe));
            check($sformatf("vec%0d_pwm_pulses", i), 96'(pwm_pul), 96'(vt[i].is_frame ? 0 : 1));
        end

        // Random traffic on the fast instance; every offered request must be accepted.
        off_f = 0; off_b = 0; acc_f = 0; acc_b = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk); #1;
            af = fv[0] && fr[0];
            ab = bv[0] && br[0];
            if (af) acc_f++;
            if (ab) acc_b++;
            @(posedge clk); #1;
            if (af) fv[0] = 1'b0;
            if (ab) bv[0] = 1'b0;
            if (c < 1500) begin
                if (!fv[0] && $urandom_range(7) == 0) begin
                    fv[0] = 1'b1; fd[0] = {$urandom(), $urandom(), $urandom()}; off_f++;
                end
                if (!bv[0] && $urandom_range(7) == 0) begin
                    bv[0] = 1'b1; bd[0] = 8'($urandom()); off_b++;
                end
            end else if (!fv[0] && !bv[0]) begin
                break;
            end
        end
        wait_idle(0, "random");
        check("random_frames_accepted", 96'(acc_f), 96'(off_f));
        check("random_brights_accepted", 96'(acc_b), 96'(off_b));
        check("invariants", 96'(viol), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
